// File: rtl/bram_ring_uart_tx.sv
// Port-B consumer of a byte ring held in dual-port BRAM: fetches each pending byte and sends it as UART (8N1).
// Define TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module bram_ring_uart_tx #(
  parameter int ADDR_W       = 12,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [7:0]        doutb,
  output logic              tx,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state, state_d;
  logic [BAUD_W-1:0]   baud_cnt, baud_d;
  logic [2:0]          bit_cnt, bit_d;
  logic [7:0]          shift, shift_d;
  logic                tx_d;
  logic                enb_d;
  logic [ADDR_W-1:0]   rd_ptr_d, addrb_d;
  logic                baud_last;
`ifdef TX_PARITY_EN
  logic                par_bit, par_d;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      enb      <= 1'b0;
      rd_ptr   <= '0;
      addrb    <= '0;
`ifdef TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
      enb      <= enb_d;
      rd_ptr   <= rd_ptr_d;
      addrb    <= addrb_d;
`ifdef TX_PARITY_EN
      par_bit  <= par_d;
`endif
    end
  end

  // Outputs are computed for the *next* state and registered, so tx and enb
  // line up exactly with the state they belong to and never glitch.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    baud_d   = '0;
    bit_d    = bit_cnt;
    shift_d  = shift;
    tx_d     = tx;
    enb_d    = 1'b0;
    rd_ptr_d = rd_ptr;
    addrb_d  = addrb;
`ifdef TX_PARITY_EN
    par_d    = par_bit;
`endif

    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (enable && (wr_ptr != rd_ptr)) begin
          state_d = S_FETCH;
          enb_d   = 1'b1;
          addrb_d = rd_ptr;
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        shift_d = doutb;
`ifdef TX_PARITY_EN
        par_d   = ^doutb;
`endif
        state_d = S_START;
        tx_d    = 1'b0;
      end

      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift[0];
        end else begin
          baud_d  = baud_cnt + 1'b1;
        end
      end

      // The byte is shifted right as it goes out; shift[1] is the next bit.
      S_DATA: begin
        if (baud_last) begin
          if (bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_bit;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_cnt + 1'b1;
            shift_d = shift >> 1;
            tx_d    = shift[1];
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_cnt + 1'b1;
        end
      end
`endif

      // The byte is only consumed once its stop bit has fully gone out.
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          state_d  = S_IDLE;
          rd_ptr_d = rd_ptr + 1'b1;
        end else begin
          baud_d   = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bram_ring_uart_tx.sv
// Bench for bram_ring_uart_tx: exact-timing frame table on a 12-bit ring, plus a
// randomised writer and UART line decoder on a small ring to exercise wrap-around.
`timescale 1ns/1ps

module tb_bram_ring_uart_tx;

  localparam int AW    = 12;
  localparam int CPB   = 4;
  localparam int AW_S  = 3;
  localparam int CPB_S = 2;
`ifdef TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NSLOT = PAR ? 11 : 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          enable;
  logic [AW-1:0] wr_ptr, rd_ptr, addrb;
  logic          enb, tx, busy;
  logic [7:0]    doutb;
  logic [7:0]    ram [0:(1<<AW)-1];

  logic            enable_s;
  logic [AW_S-1:0] wr_s, rd_s, addrb_s;
  logic            enb_s, tx_s, busy_s;
  logic [7:0]      doutb_s;
  logic [7:0]      ram_s [0:(1<<AW_S)-1];

  bram_ring_uart_tx #(.ADDR_W(AW), .CLKS_PER_BIT(CPB)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr), .addrb(addrb), .enb(enb), .doutb(doutb),
    .tx(tx), .busy(busy)
  );

  bram_ring_uart_tx #(.ADDR_W(AW_S), .CLKS_PER_BIT(CPB_S)) u_small (
    .clock(clock), .reset(reset), .enable(enable_s), .wr_ptr(wr_s),
    .rd_ptr(rd_s), .addrb(addrb_s), .enb(enb_s), .doutb(doutb_s),
    .tx(tx_s), .busy(busy_s)
  );

  always @(posedge clock) if (enb)   doutb   <= ram[addrb];
  always @(posedge clock) if (enb_s) doutb_s <= ram_s[addrb_s];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Line decoder for the small ring: samples mid-bit and records
  // {stop_ok, parity_ok, byte} for every frame seen.
  logic [9:0] got_mem [0:511];
  int         got_n = 0;
  bit         in_frame = 1'b0;
  int         mon_off;
  int         mon_slot;
  logic [7:0] mon_byte;
  logic       mon_par;

  always @(negedge clock) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_s == 1'b0) begin
        in_frame = 1'b1;
        mon_off  = 0;
      end
    end else begin
      mon_off++;
      if ((mon_off % CPB_S) == (CPB_S / 2)) begin
        mon_slot = mon_off / CPB_S;
        if (mon_slot >= 1 && mon_slot <= 8) mon_byte[mon_slot-1] = tx_s;
        else if (PAR && mon_slot == 9)      mon_par = tx_s;
        if (mon_slot == NSLOT - 1) begin
          got_mem[got_n] = {tx_s === 1'b1, !PAR || (mon_par === ^mon_byte), mon_byte};
          got_n++;
          in_frame = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = tx level in bit slot i (start, d0..d7, stop)
    logic       par;
  } vec_t;
  vec_t vecs [6];

  // Called at the negedge of the IDLE decision cycle with the byte pending;
  // returns at the negedge of the following IDLE cycle.
  task automatic check_frame(input logic [7:0] data, input logic [9:0] frame,
                             input logic par, input logic [AW-1:0] rd0, input int drop_slot);
    logic exp_tx;
    check($sformatf("idle_tx_%02h", data), tx, 1);
    check($sformatf("idle_busy_%02h", data), busy, 0);
    step();
    check($sformatf("fetch_enb_%02h", data), enb, 1);
    check($sformatf("fetch_addrb_%02h", data), addrb, rd0);
    check($sformatf("fetch_tx_%02h", data), tx, 1);
    step();
    check($sformatf("load_enb_%02h", data), enb, 0);
    check($sformatf("load_tx_%02h", data), tx, 1);
    check($sformatf("load_busy_%02h", data), busy, 1);
    for (int s = 0; s < NSLOT; s++) begin
      if (s < 9)               exp_tx = frame[s];
      else if (s == NSLOT - 1) exp_tx = 1'b1;
      else                     exp_tx = par;
      for (int k = 0; k < CPB; k++) begin
        step();
        if (s == drop_slot && k == 0) enable = 1'b0;
        check($sformatf("tx_%02h_slot%0d_c%0d", data, s, k), tx, exp_tx);
      end
    end
    check($sformatf("rd_hold_%02h", data), rd_ptr, rd0);
    step();
    check($sformatf("rd_adv_%02h", data), rd_ptr, AW'(rd0 + 1));
    check($sformatf("end_busy_%02h", data), busy, 0);
    check($sformatf("end_tx_%02h", data), tx, 1);
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    wr_ptr = '0;
    wr_s   = '0;
    step();
    step();
    reset  = 1'b0;
  endtask

  initial begin
    logic [AW-1:0]   rd;
    logic [7:0]      exp_q [$];
    logic [7:0]      b;
    logic [AW_S-1:0] used;
    int              n, saw_enb, bad_idle;

    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[2] = '{8'h00, 10'h200, 1'b0};
    vecs[3] = '{8'h07, 10'h20E, 1'b1};
    vecs[4] = '{8'h03, 10'h206, 1'b0};
    vecs[5] = '{8'h3C, 10'h278, 1'b0};

    enable   = 1'b1;
    enable_s = 1'b0;
    reset_dut();
    check("rst_tx", tx, 1);
    check("rst_rd", rd_ptr, 0);
    check("rst_addrb", addrb, 0);
    check("rst_enb", enb, 0);
    check("rst_busy", busy, 0);

    // Empty ring with enable high: nothing may happen.
    saw_enb  = 0;
    bad_idle = 0;
    repeat (50) begin
      step();
      if (enb) saw_enb = 1;
      if (tx !== 1'b1 || busy !== 1'b0) bad_idle = 1;
    end
    check("empty_enb_seen", saw_enb, 0);
    check("empty_tx_busy", bad_idle, 0);
    check("empty_rd", rd_ptr, 0);

    rd = '0;
    for (int i = 0; i < 6; i++) begin
      ram[rd] = vecs[i].data;
      wr_ptr  = rd + 1'b1;
      check_frame(vecs[i].data, vecs[i].frame, vecs[i].par, rd, -1);
      rd = rd + 1'b1;
    end

    // Three queued bytes go out back to back with a 3-cycle idle gap.
    reset_dut();
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03;
    wr_ptr = 12'd3;
    check_frame(8'h01, 10'h202, 1'b1, 12'd0, -1);
    check_frame(8'h02, 10'h204, 1'b1, 12'd1, -1);
    check_frame(8'h03, 10'h206, 1'b0, 12'd2, -1);
    check("b2b_final_rd", rd_ptr, 3);

    // Enable dropped mid-frame: frame completes, second byte waits.
    ram[3] = 8'h5A; ram[4] = 8'hC3;
    wr_ptr = 12'd5;
    check_frame(8'h5A, 10'h2B4, 1'b0, 12'd3, 3);
    saw_enb = 0;
    repeat (20) begin
      step();
      if (enb) saw_enb = 1;
    end
    check("disable_enb_seen", saw_enb, 0);
    check("disable_busy", busy, 0);
    check("disable_rd", rd_ptr, 4);
    enable = 1'b1;
    check_frame(8'hC3, 10'h386, 1'b0, 12'd4, -1);

    // Reset during data bit 3 of 8'hFF aborts the frame without consuming it.
    reset_dut();
    ram[0] = 8'hFF;
    wr_ptr = 12'd1;
    repeat (2 + 4 * CPB + 2) step();
    check("abort_pre_tx", tx, 1);
    check("abort_pre_busy", busy, 1);
    reset = 1'b1;
    step();
    check("abort_tx", tx, 1);
    check("abort_rd", rd_ptr, 0);
    check("abort_enb", enb, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    check_frame(8'hFF, 10'h3FE, 1'b0, 12'd0, -1);

    // Small ring: drain to the last index, then let wr_ptr wrap to 0.
    reset_dut();
    enable_s = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ram_s[i] = 8'($urandom);
      exp_q.push_back(ram_s[i]);
    end
    ram_s[7] = 8'h3C;
    wr_s = 3'd7;
    for (int i = 0; i < 400 && !(rd_s == 3'd7 && !busy_s); i++) step();
    check("wrap_pre_rd", rd_s, 7);
    wr_s = 3'd0;
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 100 && !(rd_s == 3'd0 && !busy_s); i++) step();
    check("wrap_rd", rd_s, 0);
    saw_enb = 0;
    repeat (30) begin
      step();
      if (enb_s) saw_enb = 1;
    end
    check("wrap_idle_enb", saw_enb, 0);
    check("wrap_count", got_n, 8);
    check("wrap_byte", got_mem[7][7:0], 8'h3C);

    // Random writer bursts with random enable; output order must match writes.
    for (int it = 0; it < 40; it++) begin
      enable_s = ($urandom_range(0, 7) != 0);
      used = wr_s - rd_s;
      n = $urandom_range(0, 7 - int'(used));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        ram_s[wr_s] = b;
        exp_q.push_back(b);
        wr_s = wr_s + 1'b1;
      end
      repeat ($urandom_range(1, 60)) step();
    end
    enable_s = 1'b1;
    for (int i = 0; i < 3000 && got_n < exp_q.size(); i++) step();
    repeat (5) step();
    check("rand_count", got_n, exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_n; j++) begin
      check($sformatf("rand_byte%0d", j), got_mem[j][7:0], exp_q[j]);
      check($sformatf("rand_frame%0d", j), got_mem[j][9:8], 2'b11);
    end
    check("rand_rd_final", rd_s, wr_s);
    check("rand_busy_final", busy_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
